// File: rtl/rv32m_muldiv_unit_pkg.sv
// Shared definitions for the RV32M multiply/divide unit: funct3 encodings,
// FSM state encoding, special-result constants and operand-sign helpers.
package muldiv_pkg;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [31:0] DIV0_QUOT = 32'hFFFF_FFFF;
  localparam logic [31:0] INT_MIN   = 32'h8000_0000;

  // rs1 is treated as signed by everything except the unsigned-only ops
  function automatic logic op_signed_a(input logic [2:0] f3);
    return (f3 != F3_MULHU) && (f3 != F3_DIVU) && (f3 != F3_REMU);
  endfunction

  // rs2 is signed only for the fully signed ops (MULHSU keeps it unsigned)
  function automatic logic op_signed_b(input logic [2:0] f3);
    return (f3 == F3_MUL) || (f3 == F3_MULH) || (f3 == F3_DIV) || (f3 == F3_REM);
  endfunction

endpackage

// File: rtl/rv32m_muldiv_unit_if.sv
// EX-stage bundle between the pipeline (master) and the mul/div unit (slave).
interface rv32m_muldiv_unit_if #(parameter int N = 32);

  logic         start;
  logic [2:0]   funct3;
  logic [N-1:0] rs1;
  logic [N-1:0] rs2;
  logic         flush;
  logic         stall;
  logic         done;
  logic [N-1:0] result;

  modport master (
    output start, funct3, rs1, rs2, flush,
    input  stall, done, result
  );

  modport slave (
    input  start, funct3, rs1, rs2, flush,
    output stall, done, result
  );

endinterface

// File: rtl/rv32m_muldiv_unit_abs_neg.sv
// Conditional two's-complement negate, used both to take operand magnitudes
// and to restore the sign of the finished product/quotient/remainder.
module muldiv_abs_neg #(
  parameter int N = 32
) (
  input  logic [N-1:0] in,
  input  logic         neg,
  output logic [N-1:0] out
);

  // negate when requested, otherwise pass straight through
  always_comb begin
    out = neg ? ((~in) + N'(1)) : in;
  end

endmodule

// File: rtl/rv32m_muldiv_unit.sv
// Iterative RV32M multiply/divide unit for the EX stage.
// Multiply is shift-add, divide is restoring, both on magnitudes, one bit per
// cycle, followed by a sign-fix cycle. Divide-by-zero and signed overflow
// finish in one cycle. Defining MULDIV_FAST_MUL_EN replaces the iterative
// multiply with a single-cycle combinational multiplier.
module rv32m_muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int N = 32
) (
  input logic                 clk,
  input logic                 rst,
  rv32m_muldiv_unit_if.slave  bus
);

  state_t       state;
  state_t       state_nxt;
  logic [4:0]   cnt;
  logic [2:0]   op;
  logic         a_neg;
  logic         b_neg;
  logic [N-1:0] hi;
  logic [N-1:0] lo;
  logic [N-1:0] opb;
  logic         done_q;
  logic [N-1:0] result_q;
  logic         stall;

  logic         sa;
  logic         sb;
  logic [N-1:0] rs1_abs;
  logic [N-1:0] rs2_abs;
  logic         accept;
  logic         div_zero;
  logic         div_ovf;
  logic         shortcut;
  logic [N-1:0] shortcut_res;
  logic [N-1:0] special_res;

  logic [N:0]     mul_acc;
  logic [N:0]     div_shift;
  logic [N:0]     div_diff;
  logic [2*N-1:0] prod_fix;
  logic [N-1:0]   div_sel;
  logic           div_sel_neg;
  logic [N-1:0]   div_fix;
  logic [N-1:0]   fix_res;

  assign sa = op_signed_a(bus.funct3) & bus.rs1[N-1];
  assign sb = op_signed_b(bus.funct3) & bus.rs2[N-1];

  muldiv_abs_neg #(.N(N)) u_abs_a (.in(bus.rs1), .neg(sa), .out(rs1_abs));
  muldiv_abs_neg #(.N(N)) u_abs_b (.in(bus.rs2), .neg(sb), .out(rs2_abs));

  // spot the one-cycle cases (divide specials, and fast multiply if enabled)
  always_comb begin
    accept   = (state == IDLE) && bus.start && !bus.flush;
    div_zero = bus.funct3[2] && (bus.rs2 == '0);
    div_ovf  = bus.funct3[2] && !bus.funct3[0] &&
               (bus.rs1 == INT_MIN) && (bus.rs2 == DIV0_QUOT);
    if (div_zero) begin
      special_res = bus.funct3[1] ? bus.rs1 : DIV0_QUOT;
    end else begin
      special_res = bus.funct3[1] ? '0 : INT_MIN;
    end
  end

`ifdef MULDIV_FAST_MUL_EN
  logic [2*N-1:0] fast_prod;

  // single-cycle multiply on sign-extended operands; low 64 bits are exact
  always_comb begin
    fast_prod = {{N{sa}}, bus.rs1} * {{N{sb}}, bus.rs2};
    shortcut  = !bus.funct3[2] || div_zero || div_ovf;
    if (!bus.funct3[2]) begin
      shortcut_res = (bus.funct3 == F3_MUL) ? fast_prod[N-1:0] : fast_prod[2*N-1:N];
    end else begin
      shortcut_res = special_res;
    end
  end
`else
  // only the divide specials bypass the iteration
  always_comb begin
    shortcut     = div_zero || div_ovf;
    shortcut_res = special_res;
  end
`endif

  // one iteration step for each algorithm, plus the sign fix of the outcome
  always_comb begin
    mul_acc     = {1'b0, hi} + (lo[0] ? {1'b0, opb} : '0);
    div_shift   = {hi, lo[N-1]};
    div_diff    = div_shift - {1'b0, opb};
    div_sel     = op[1] ? hi : lo;
    div_sel_neg = op[1] ? a_neg : (a_neg ^ b_neg);
    if (op[2]) begin
      fix_res = div_fix;
    end else if (op == F3_MUL) begin
      fix_res = prod_fix[N-1:0];
    end else begin
      fix_res = prod_fix[2*N-1:N];
    end
  end

  muldiv_abs_neg #(.N(2*N)) u_fix_prod (.in({hi, lo}), .neg(a_neg ^ b_neg), .out(prod_fix));
  muldiv_abs_neg #(.N(N))   u_fix_div  (.in(div_sel),  .neg(div_sel_neg),   .out(div_fix));

  // state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // next-state logic; flush squashes from any state
  always_comb begin
    state_nxt = state;
    if (bus.flush) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE: if (bus.start) state_nxt = shortcut ? DONE : CALC;
        CALC: if (cnt == 5'd31) state_nxt = FIX;
        FIX:  state_nxt = DONE;
        DONE: state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // hold the pipeline from acceptance until the result is ready
  always_comb begin
    stall = ((state == IDLE) && bus.start && !bus.flush) ||
            (state == CALC) || (state == FIX);
  end

  // datapath: latch operands, iterate, and register the final result
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt      <= '0;
      op       <= '0;
      a_neg    <= 1'b0;
      b_neg    <= 1'b0;
      hi       <= '0;
      lo       <= '0;
      opb      <= '0;
      done_q   <= 1'b0;
      result_q <= '0;
    end else begin
      done_q <= (state_nxt == DONE);
      case (state)
        IDLE: begin
          if (accept) begin
            op    <= bus.funct3;
            a_neg <= sa;
            b_neg <= sb;
            cnt   <= '0;
            hi    <= '0;
            lo    <= bus.funct3[2] ? rs1_abs : rs2_abs;
            opb   <= bus.funct3[2] ? rs2_abs : rs1_abs;
            if (shortcut) begin
              result_q <= shortcut_res;
            end
          end
        end
        CALC: begin
          cnt <= cnt + 5'd1;
          if (op[2]) begin
            if (!div_diff[N]) begin
              hi <= div_diff[N-1:0];
              lo <= {lo[N-2:0], 1'b1};
            end else begin
              hi <= div_shift[N-1:0];
              lo <= {lo[N-2:0], 1'b0};
            end
          end else begin
            hi <= mul_acc[N:1];
            lo <= {mul_acc[0], lo[N-1:1]};
          end
        end
        FIX: begin
          if (!bus.flush) begin
            result_q <= fix_res;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.stall  = stall;
  assign bus.done   = done_q;
  assign bus.result = result_q;

endmodule

// File: tb/tb_rv32m_muldiv_unit.sv
// Scoreboard bench for rv32m_muldiv_unit: stimulus pushes expected results
// computed from plain arithmetic, a negedge monitor pops and compares them
// whenever done is seen. Honours MULDIV_FAST_MUL_EN for expected latency.
module tb_rv32m_muldiv_unit;
  import muldiv_pkg::*;

  typedef struct {
    logic [31:0] res;
    int          due;
    string       name;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t sbq[$];
  exp_t mon_e;
  logic [31:0] last_res = '0;
  logic        rst_prev = 1'b1;

  rv32m_muldiv_unit_if bus ();

  rv32m_muldiv_unit dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, want 0x%08h", name, act, req);
    end
  endtask

  function automatic logic [31:0] refModel(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    longint      sa;
    longint      sb;
    logic [63:0] ua;
    logic [63:0] ub;
    logic [63:0] p;
    int          ia;
    int          ib;
    sa = $signed(a);
    sb = $signed(b);
    ua = {32'd0, a};
    ub = {32'd0, b};
    ia = a;
    ib = b;
    case (f3)
      F3_MUL:    begin p = ua * ub;               return p[31:0];  end
      F3_MULH:   begin p = sa * sb;               return p[63:32]; end
      F3_MULHSU: begin p = sa * longint'(ub);     return p[63:32]; end
      F3_MULHU:  begin p = ua * ub;               return p[63:32]; end
      F3_DIV: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        return ia / ib;
      end
      F3_REM: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        return ia % ib;
      end
      F3_DIVU: begin
        if (b == 0) return 32'hFFFF_FFFF;
        return a / b;
      end
      default: begin
        if (b == 0) return a;
        return a % b;
      end
    endcase
  endfunction

  function automatic int refLatency(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    if (f3[2] && b == 0) return 1;
    if ((f3 == F3_DIV || f3 == F3_REM) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
`ifdef MULDIV_FAST_MUL_EN
    if (!f3[2]) return 1;
`endif
    return 34;
  endfunction

  function automatic logic [31:0] pickOperand();
    case ($urandom_range(0, 7))
      0:       return 32'h0000_0000;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h0000_0001;
      default: return $urandom;
    endcase
  endfunction

  // called just after a rising edge; holds start like a stalled pipeline
  // until the result cycle, scrambling operands while busy
  task automatic applyStimulus(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b, input string name);
    int lat;
    int stalls;
    bit seen;
    exp_t e;
    lat        = refLatency(f3, a, b);
    bus.start  = 1'b1;
    bus.funct3 = f3;
    bus.rs1    = a;
    bus.rs2    = b;
    e.res  = refModel(f3, a, b);
    e.due  = cyc + lat;
    e.name = name;
    sbq.push_back(e);
    stalls = 0;
    seen   = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      if (bus.stall) stalls++;
      if (bus.done) seen = 1'b1;
      @(posedge clk);
      #1;
      if (!seen) begin
        bus.rs1 = $urandom;
        bus.rs2 = $urandom;
      end
    end
    bus.start = 1'b0;
    if (!seen) begin
      checks++;
      errors++;
      $display("[TB] FAIL %s timeout: got no done, want done within 100 cycles", name);
      if (sbq.size() > 0) void'(sbq.pop_back());
    end else begin
      checkOutput({name, " stall cycles"}, stalls, lat);
    end
  endtask

  // start a divide, squash it on cycle T+10, and confirm nothing completes
  task automatic applyFlush(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] held;
    held       = bus.result;
    bus.start  = 1'b1;
    bus.funct3 = F3_DIV;
    bus.rs1    = a;
    bus.rs2    = b;
    repeat (10) @(posedge clk);
    #1;
    bus.flush = 1'b1;
    @(negedge clk);
    checkOutput("stall before flush", bus.stall, 1'b1);
    @(posedge clk);
    #1;
    bus.flush = 1'b0;
    bus.start = 1'b0;
    @(negedge clk);
    checkOutput("flush stall", bus.stall, 1'b0);
    checkOutput("flush done", bus.done, 1'b0);
    checkOutput("flush result", bus.result, held);
    repeat (40) @(negedge clk);
    @(posedge clk);
    #1;
  endtask

  // start an iterative op, hit reset on cycle T+20, check everything cleared
  task automatic applyMidReset(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    bus.start  = 1'b1;
    bus.funct3 = f3;
    bus.rs1    = a;
    bus.rs2    = b;
    repeat (20) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst       = 1'b0;
    bus.start = 1'b0;
    @(negedge clk);
    checkOutput("mid-reset done", bus.done, 1'b0);
    checkOutput("mid-reset result", bus.result, 32'd0);
    checkOutput("mid-reset stall", bus.stall, 1'b0);
    repeat (40) @(negedge clk);
    @(posedge clk);
    #1;
  endtask

  // monitor: score every done pulse and check result holds between pulses
  always @(negedge clk) begin
    if (bus.done) begin
      if (sbq.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected done: got done=1, want done=0 (result 0x%08h)", bus.result);
      end else begin
        mon_e = sbq.pop_front();
        checkOutput({mon_e.name, " result"}, bus.result, mon_e.res);
        checkOutput({mon_e.name, " latency"}, cyc, mon_e.due);
      end
    end else if (!rst_prev && !rst) begin
      checkOutput("result hold", bus.result, last_res);
    end
    last_res = bus.result;
    rst_prev = rst;
  end

  initial begin
    rst        = 1'b1;
    bus.start  = 1'b0;
    bus.funct3 = 3'd0;
    bus.rs1    = 32'd0;
    bus.rs2    = 32'd0;
    bus.flush  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    checkOutput("reset done", bus.done, 1'b0);
    checkOutput("reset result", bus.result, 32'd0);
    checkOutput("reset stall", bus.stall, 1'b0);
    @(posedge clk);
    #1;

    applyStimulus(F3_MUL,    32'h0000_0007, 32'hFFFF_FFFD, "MUL 7*-3");
    applyStimulus(F3_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, "MULHU -1*-1");
    applyStimulus(F3_MULH,   32'hFFFF_FFFF, 32'hFFFF_FFFF, "MULH -1*-1");
    applyStimulus(F3_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "MULHSU -1*-1");
    applyStimulus(F3_DIV,    32'hFFFF_FFF9, 32'h0000_0002, "DIV -7/2");
    applyStimulus(F3_REM,    32'hFFFF_FFF9, 32'h0000_0002, "REM -7/2");
    applyStimulus(F3_DIVU,   32'd100,       32'd7,         "DIVU 100/7");
    applyStimulus(F3_REMU,   32'd100,       32'd7,         "REMU 100/7");
    applyStimulus(F3_DIVU,   32'd5,         32'd0,         "DIVU 5/0");
    applyStimulus(F3_REM,    32'd5,         32'd0,         "REM 5/0");
    applyStimulus(F3_DIV,    32'h8000_0000, 32'hFFFF_FFFF, "DIV overflow");
    applyStimulus(F3_REM,    32'h8000_0000, 32'hFFFF_FFFF, "REM overflow");

    applyFlush(32'hFFFF_FFF9, 32'h0000_0002);
    applyStimulus(F3_MUL,    32'h0000_0007, 32'hFFFF_FFFD, "MUL after flush");
`ifdef MULDIV_FAST_MUL_EN
    applyMidReset(F3_DIVU, 32'd1000, 32'd3);
`else
    applyMidReset(F3_MUL, 32'h0000_0007, 32'hFFFF_FFFD);
`endif
    applyStimulus(F3_MUL,    32'h0000_0007, 32'hFFFF_FFFD, "MUL after reset");

    for (int i = 0; i < 40; i++) begin
      logic [2:0]  f3;
      logic [31:0] a;
      logic [31:0] b;
      f3 = 3'($urandom_range(0, 7));
      a  = pickOperand();
      b  = pickOperand();
      applyStimulus(f3, a, b, $sformatf("random%0d f3=%0d a=%08h b=%08h", i, f3, a, b));
    end

    repeat (5) @(posedge clk);
    checkOutput("scoreboard drained", sbq.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/rv32m_muldiv_unit.md
# rv32m_muldiv_unit

Iterative RV32M multiply/divide unit in the EX stage, alongside the ALU. Accepts one M-extension operation at a time from the ID/EX register. Holds the pipeline through a combinational stall request while it iterates. Presents a one-cycle-valid 32-bit result that the EX result-select 2x1 mux routes instead of the ALU output.

## Interface
- `N`, 32, operand/result width (only 32 supported)
- `clk` input 1, rising-edge clock
- `rst` input 1, synchronous, active-high reset
- `start` input 1, EX instruction is an M-extension op (opcode 0110011, funct7 0000001)
- `funct3` input 3, operation select: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- `rs1` input N, operand A (dividend / multiplicand)
- `rs2` input N, operand B (divisor / multiplier)
- `flush` input 1, abort the in-flight operation (branch/exception squash)
- `stall` output 1, combinational request to freeze PC, IF/ID and ID/EX
- `done` output 1, registered, result valid this cycle
- `result` output N, registered result; holds its last value when `done`=0

## Operation
- States: IDLE, CALC, FIX, DONE.
- IDLE:
  - `start`=1 and `flush`=0 latch operands, `funct3` and sign flags.
  - Normal next state is CALC with counter=0.
  - Divide with `rs2`=0 goes directly to DONE.
  - DIV/REM with `rs1`=0x80000000 and `rs2`=0xFFFFFFFF goes directly to DONE.
- CALC:
  - Multiply: shift-add on absolute values, 64-bit product register.
  - Divide: restoring division on absolute values, 32-bit remainder and quotient.
  - One bit per cycle; counter 0..31; counter=31 moves to FIX.
- FIX: apply result sign.
  - Product is negated when signs differ, for MULH (both signed) and MULHSU (rs1 signed only).
  - Quotient is negated when signs differ.
  - Remainder takes the dividend's sign.
  - Select the low or high word by `funct3`; register into `result`. Next state DONE.
- DONE: `done`=1 for exactly one cycle; next state IDLE. A `start` seen in DONE is not accepted.
- Special results:
  - Divide by zero: quotient 0xFFFFFFFF, remainder = `rs1`.
  - Signed overflow: quotient 0x80000000, remainder 0.
- `flush`=1 in any state: next state IDLE, `done` stays 0, `result` unchanged. `flush` has priority over `start`.
- `stall` = (IDLE and `start` and not `flush`) or CALC or FIX. It is 0 in DONE, so the instruction advances with the valid result.

## Timing
- Reset values: state IDLE, `done` 0, `result` 0, counter 0, internal registers 0. `stall` is 0 after reset while `start`=0.
- `rst` has priority over `flush` and `start`. Reset mid-operation discards the operation with no `done` pulse.
- Iterative operation accepted at edge T: CALC for cycles T+1..T+32, FIX at T+33, `done`=1 during cycle T+34 (latency 34).
- Special-case divide: `done`=1 during cycle T+1 (latency 1).
- Back-to-back ops: the next op is accepted no earlier than the cycle after DONE, when the pipeline presents the next instruction.
- Operands are sampled only at acceptance. Changes to `rs1`/`rs2` while busy are ignored.

## Configuration
- `MULDIV_FAST_MUL_EN` defined:
  - MUL/MULH/MULHSU/MULHU use a single-cycle 64-bit combinational multiplier. IDLE goes to DONE; `done` is asserted at T+1.
  - Division is unchanged.
- `MULDIV_FAST_MUL_EN` undefined: multiply uses the 34-cycle iterative path above.

## Structure
- Package `muldiv_pkg` holds:
  - funct3 localparams (`F3_MUL` … `F3_REMU`);
  - state encoding (IDLE=2'd0, CALC=2'd1, FIX=2'd2, DONE=2'd3);
  - constants `DIV0_QUOT`=32'hFFFFFFFF, `INT_MIN`=32'h80000000.
- Sub-module `muldiv_abs_neg`: combinational N-bit conditional two's-complement negate (`in`, `neg`, `out`). Instantiated for operand abs values and in FIX.

## Test plan
- MUL 7 × −3 (0x00000007, 0xFFFFFFFD) -> `stall` high T..T+33; `done` at T+34; `result`=0xFFFFFFEB.
- MULHU 0xFFFFFFFF × 0xFFFFFFFF -> 0xFFFFFFFE. MULH same operands -> 0x00000000. MULHSU same operands -> 0xFFFFFFFF.
- DIV −7 / 2 -> 0xFFFFFFFD; REM −7 / 2 -> 0xFFFFFFFF; DIVU 100 / 7 -> 14; REMU 100 / 7 -> 2.
- DIVU 5 / 0 -> 0xFFFFFFFF with `done` at T+1. REM 5 / 0 -> 5. DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000. REM same operands -> 0.
- `flush` at T+10 of a DIV -> state IDLE at T+11; no `done`; `result` unchanged. A new MUL then completes normally.
- `rst` at T+20 of a MUL -> `done` 0, `result` 0, `stall` 0 next cycle. With `MULDIV_FAST_MUL_EN`, MUL 7 × −3 -> `done` at T+1 with 0xFFFFFFEB.
